// File: rtl/instruction_utils.sv
// Shared fetch-stage definitions: state encoding and instruction/PC constants.
package instruction_utils;

  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    WAIT_BR,
    TRAP
  } fetch_state_e;

endpackage

// File: rtl/fetch.sv
// Instruction fetch stage: single outstanding memory request, one-entry
// instruction holding register, redirect handling and misaligned-target trap.
module fetch #(
  parameter logic [31:0] RESET_PC  = instruction_utils::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = instruction_utils::INSTR_NOP
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        id_ready,
  input  logic        stall_if,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        misaligned
);
  import instruction_utils::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  tgt_q, tgt_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  ipc_q, ipc_d;
  logic         valid_q, valid_d;
  logic         discard_q, discard_d;
  logic         mis_q, mis_d;
  logic         run_q;

  logic req, resp, outstanding, tgt_aligned;

  // A TRAP entered mid-request keeps the request up until its response drains.
  assign req         = run_q && ((state_q == FETCH) || ((state_q == TRAP) && discard_q));
  assign resp        = req && imem_rvalid;
  assign outstanding = req && !imem_rvalid;
  assign tgt_aligned = (redirect_pc[1:0] == 2'b00);

  assign imem_req    = req;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign misaligned  = mis_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    instr_d   = instr_q;
    ipc_d     = ipc_q;
    valid_d   = valid_q;
    discard_d = discard_q;
    mis_d     = mis_q;

    if (redirect_valid) begin
      valid_d   = 1'b0;
      instr_d   = NOP_INSTR;
      mis_d     = !tgt_aligned;
      state_d   = tgt_aligned ? FETCH : TRAP;
      // With a request in flight the address must stay put; the target is
      // parked and loaded into pc when the stale response arrives.
      discard_d = outstanding;
      tgt_d     = redirect_pc;
      if (!outstanding && tgt_aligned) pc_d = redirect_pc;
    end else begin
      case (state_q)
        FETCH: begin
          if (resp) begin
            if (discard_q) begin
              discard_d = 1'b0;
              pc_d      = tgt_q;
            end else begin
              state_d = HOLD;
              instr_d = imem_rdata;
              ipc_d   = pc_q;
              valid_d = 1'b1;
            end
          end
        end
        HOLD: begin
          if (id_ready) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            if (stall_if) begin
              state_d = WAIT_BR;
            end else begin
              state_d = FETCH;
              pc_d    = pc_q + 32'd4;
            end
          end
        end
        WAIT_BR: state_d = WAIT_BR;
        TRAP: begin
          if (resp) discard_d = 1'b0;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      tgt_q     <= '0;
      instr_q   <= NOP_INSTR;
      ipc_q     <= '0;
      valid_q   <= 1'b0;
      discard_q <= 1'b0;
      mis_q     <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tgt_q     <= tgt_d;
      instr_q   <= instr_d;
      ipc_q     <= ipc_d;
      valid_q   <= valid_d;
      discard_q <= discard_d;
      mis_q     <= mis_d;
      run_q     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed scenarios plus randomized traffic
// against a transaction-level reference model and a variable-latency memory.
module tb_fetch;
  import instruction_utils::*;

  localparam logic [31:0] NOP = INSTR_NOP;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = '0;
  logic [31:0] instr, instr_pc;
  logic        instr_valid, misaligned;
  logic        id_ready = 1'b0, stall_if = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic        w_req, w_valid, w_mis;
  logic [31:0] w_addr, w_instr, w_ipc;
  logic        w_rvalid = 1'b0;
  logic [31:0] w_rdata  = '0;

  fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .id_ready(id_ready), .stall_if(stall_if),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .misaligned(misaligned)
  );

  fetch #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .instr(w_instr), .instr_pc(w_ipc), .instr_valid(w_valid),
    .id_ready(1'b1), .stall_if(1'b0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .misaligned(w_mis)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  // Reference model: exp_pc is the next address to be both fetched and delivered.
  logic [31:0] exp_pc, exp_instr, exp_ipc, maddr;
  bit          exp_valid, holding, waiting, trap, stale, busy, started;
  int unsigned mcnt, mem_lat;
  logic [31:0] req_log[$];

  task automatic model_reset();
    exp_pc = 32'h0; exp_instr = NOP; exp_ipc = 32'h0; maddr = 32'h0;
    exp_valid = 0; holding = 0; waiting = 0; trap = 0; stale = 0; busy = 0; started = 0;
    mcnt = 0;
    req_log.delete();
  endtask

  // Called at a falling edge: check outputs, play memory, drive inputs, advance model.
  task automatic step(input bit rdy, input bit stall, input bit redir, input logic [31:0] rpc);
    bit rv;
    bit allow;
    check_eq("valid", instr_valid, exp_valid);
    if (exp_valid) begin
      check_eq("instr", instr, exp_instr);
      check_eq("instr_pc", instr_pc, exp_ipc);
    end else begin
      check_eq("nop", instr, NOP);
    end
    check_eq("misaligned", misaligned, trap);

    rv    = 0;
    allow = started && !holding && !waiting && !trap;
    if (busy) begin
      check_eq("req_held", imem_req, 1);
      check_eq("addr_stable", imem_addr, maddr);
      mcnt--;
      rv = (mcnt == 0);
    end else begin
      check_eq("req_level", imem_req, allow);
      if (imem_req) begin
        check_eq("req_addr", imem_addr, exp_pc);
        req_log.push_back(imem_addr);
        busy  = 1;
        maddr = imem_addr;
        mcnt  = (mem_lat != 0) ? mem_lat : $urandom_range(1, 3);
      end
    end

    imem_rvalid    = rv;
    imem_rdata     = rv ? mem_word(maddr) : $urandom;
    id_ready       = rdy;
    stall_if       = stall;
    redirect_valid = redir;
    redirect_pc    = rpc;

    if (redir) begin
      exp_valid = 0; holding = 0; waiting = 0;
      stale = busy && !rv;
      if (rpc[1:0] == 2'b00) begin
        exp_pc = rpc;
        trap   = 0;
      end else begin
        trap = 1;
      end
    end else if (rv) begin
      if (stale) begin
        stale = 0;
      end else begin
        holding = 1; exp_valid = 1; exp_instr = mem_word(maddr); exp_ipc = maddr;
      end
    end else if (holding && rdy) begin
      holding = 0; exp_valid = 0;
      if (stall) waiting = 1;
      else exp_pc = exp_pc + 32'd4;
    end
    if (rv) busy = 0;
    started = 1;

    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_until_hold(input logic [31:0] target, input int unsigned budget);
    int unsigned n = 0;
    while (!(exp_valid && exp_ipc == target) && n < budget) begin
      step(1, 0, 0, 32'h0);
      n++;
    end
    check_eq("reach_valid", instr_valid, 1);
    check_eq("reach_pc", instr_pc, target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rpc;
    logic [31:0] w_log[$];
    bit          w_busy;

    mem_lat = 1;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_req", imem_req, 0);
    check_eq("rst_valid", instr_valid, 0);
    check_eq("rst_instr", instr, NOP);
    check_eq("rst_ipc", instr_pc, 32'h0);
    check_eq("rst_mis", misaligned, 0);
    check_eq("rst_wrap_req", w_req, 0);
    rst_n = 1'b1;

    // Sequential fetch, then decode back-pressure at pc 8
    run_until_hold(32'h8, 40);
    repeat (3) begin
      step(0, 0, 0, 32'h0);
      check_eq("bp_pc", instr_pc, 32'h8);
      check_eq("bp_noreq", imem_req, 0);
    end
    run_until_hold(32'hC, 20);
    check_eq("req_count", req_log.size(), 4);
    for (int unsigned i = 0; i < 4; i++)
      if (i < req_log.size()) check_eq("seq_addr", req_log[i], i * 4);

    // Control-flow stall at 16, released by redirect to 0x100
    run_until_hold(32'h10, 20);
    step(1, 1, 0, 32'h0);
    repeat (4) begin
      step(1, 0, 0, 32'h0);
      check_eq("wait_br_noreq", imem_req, 0);
    end
    mem_lat = 3;
    step(1, 0, 1, 32'h100);
    check_eq("redir100_req", imem_req, 1);
    check_eq("redir100_addr", imem_addr, 32'h100);

    // Redirect to 0x200 while the 0x100 request is outstanding
    step(1, 0, 0, 32'h0);
    step(1, 0, 1, 32'h200);
    mem_lat = 1;
    run_until_hold(32'h200, 20);

    // Misaligned target traps; an aligned redirect recovers
    step(0, 0, 1, 32'h202);
    repeat (3) begin
      check_eq("trap_mis", misaligned, 1);
      check_eq("trap_noreq", imem_req, 0);
      step(0, 0, 0, 32'h0);
    end
    step(0, 0, 1, 32'h300);
    check_eq("clr_mis", misaligned, 0);
    check_eq("redir300_req", imem_req, 1);
    check_eq("redir300_addr", imem_addr, 32'h300);

    // Redirect in the same cycle as the response
    step(1, 0, 0, 32'h0);
    step(1, 0, 1, 32'h400);
    check_eq("coinc_req", imem_req, 1);
    check_eq("coinc_addr", imem_addr, 32'h400);
    check_eq("coinc_valid", instr_valid, 0);

    // Randomized traffic
    mem_lat = 0;
    repeat (800) begin
      rpc = $urandom & 32'h0000_0FFC;
      if ($urandom_range(0, 4) == 0) rpc = rpc | 32'($urandom_range(1, 3));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 24) == 0, rpc);
    end

    // PC wrap on the instance reset to 0xFFFF_FFFC
    id_ready = 1'b0; stall_if = 1'b0; redirect_valid = 1'b0; imem_rvalid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    w_busy = 0;
    for (int c = 0; c < 30 && w_log.size() < 2; c++) begin
      w_rvalid = 1'b0;
      if (w_busy) begin
        w_rvalid = 1'b1;
        w_rdata  = mem_word(w_addr);
        w_busy   = 0;
      end else if (w_req) begin
        w_log.push_back(w_addr);
        w_busy = 1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    w_rvalid = 1'b0;
    check_eq("wrap_count", w_log.size(), 2);
    if (w_log.size() > 0) check_eq("wrap_first", w_log[0], 32'hFFFF_FFFC);
    if (w_log.size() > 1) check_eq("wrap_second", w_log[1], 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
